vect_relu_argmax: RTL and testbench
===================================

# vect_relu_argmax

Post-layer activation stage that sits directly downstream of `matrixvect_mult`. Once the multiplier reports done, it streams the length-M float32 result vector y out of the y BRAM and applies ReLU to each element. It writes the activated vector to an output BRAM, which becomes the x BRAM of the next layer, and optionally reports the index of the largest activated element. Control and status use the same PS-facing `ps_control`/`pl_status` register convention as the multiplier.

## Interface
Parameters:
- `addr_y_size`, default 12: byte-address width of the y BRAM port.
- `addr_o_size`, default 12: byte-address width of the output BRAM port.
- `length_M`, default 128: number of elements processed per run; legal range 1..4096.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `ps_control` in 32: bit 0 is start/hold; other bits are ignored.
- `pl_status` out 32: bit 0 done, bit 1 busy, bits 31:16 argmax index, other bits 0.
- `bram_addr_y` out `addr_y_size`: byte address, always 4·i.
- `bram_rddata_y` in 32: y word; valid one cycle after its address is registered into the BRAM.
- `bram_wrdata_y` out 32: tied to 0.
- `bram_we_y` out 4: tied to 0.
- `bram_addr_o` out `addr_o_size`: byte address, always 4·i.
- `bram_rddata_o` in 32: unused.
- `bram_wrdata_o` out 32: activated element.
- `bram_we_o` out 4: 4'hF while writing, 4'h0 otherwise.

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `ps_control[0]==1`. Clear the index counter, the argmax index and the best value.
- RUN: present `bram_addr_y = 4·i` for i = 0..length_M−1, one per cycle. After the last address, go to DRAIN.
- DRAIN: 2 cycles, which flush the read-latency pipeline. Then go to DONE.
- DONE: `pl_status[0]=1`. Stay in DONE while `ps_control[0]==1`; go to IDLE the cycle after it reads 0.
- If `ps_control[0]` drops during RUN or DRAIN, it is ignored. The run completes and done is held for exactly one cycle.
- ReLU rule for each word w (all rules are bit-level; there is no floating-point IP):
  - sign=1 → 32'h0000_0000. This includes −0 and negative denormals.
  - exp=8'hFF with mantissa≠0 (NaN) → 32'h7FC0_0000, and the element is excluded from argmax.
  - +Inf and positive values pass through unchanged.
- Argmax compares post-ReLU words as unsigned 31-bit integers. This is exact for non-negative IEEE-754 values.
- The argmax update is a strict greater-than, so ties keep the lowest index.
- The initial best value is 0 with index 0, so an all-zero or all-negative vector reports index 0.
- `bram_we_o` is only ever 4'h0 or 4'hF.
- `reset` asserted in any state:
  - Next edge: state IDLE and all outputs 0, including `bram_we_o` (a pending write is dropped).
  - Output BRAM contents already written are left as they are.

## Timing
- Edge 0 is the edge that samples start in IDLE. After edge 0, `bram_addr_y = 0`; after edge i, `bram_addr_y = 4·i`.
- The element addressed at edge i is written with `bram_addr_o = 4·i`, `bram_we_o = 4'hF`, registered at edge i+2.
- Throughput is 1 element per cycle.
- Last write is registered at edge length_M+1. `pl_status[0]` rises after edge length_M+2, with `pl_status[31:16]` final at the same time.
- `pl_status[1]` (busy) is high in RUN and DRAIN only.
- Reset values: `pl_status = 0`; all BRAM addresses, write data and write enables 0.
- Back-to-back runs: the earliest restart is 2 cycles after DONE exits (DONE→IDLE, then IDLE samples start).

## Configuration
- Macro: `VECT_RELU_ARGMAX_EN`.
- Defined: the argmax comparator and index register are built, and `pl_status[31:16]` reports the index.
- Undefined: both are removed, and `pl_status[31:16]` is constant 0.
- ReLU, writes and timing are identical in both builds.

## Structure
- The shared package `bb_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the constants `FP32_ZERO` (32'h0) and `FP32_QNAN` (32'h7FC0_0000);
  - the `pl_status` bit positions.
- One sub-module, `fp32_relu`, holds the combinational ReLU/NaN classification:
  - input: 32-bit word;
  - outputs: 32-bit result and 1-bit `is_nan`.
- The pipeline registers, counters and argmax live in the top level.

## Test plan
- y all 32'h3F80_0000, length_M=128, start → 128 writes of 32'h3F80_0000 at addresses 0..508; done after edge 130; argmax 0.
- y[5]=32'hC120_0000 (−10), y[9]=32'h4120_0000, y[70]=32'h42C8_0000, others 0 → out[5]=0, out[9]=32'h4120_0000; argmax 70.
- y[3]=y[40]=32'h4248_0000, y[1]=32'h7FC1_2345 → out[1]=32'h7FC0_0000; argmax 3 (tie resolves to the lower index, NaN excluded); y[0]=32'h8000_0000 → out[0]=0.
- Reset asserted at edge 60 of a run → next edge: `bram_we_o=0`, `pl_status=0`, state IDLE; a new start then completes normally.
- `ps_control[0]` dropped at edge 20 → all 128 writes occur; `pl_status[0]` is high for exactly one cycle.
- Build without `VECT_RELU_ARGMAX_EN` and repeat the second scenario → identical output BRAM contents; `pl_status[31:16]=0`.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared types and constants for the post-layer activation blocks:
// run-state encoding, fp32 special words and pl_status bit positions.
package bb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_IDX_LSB = 16;

endpackage

// File: rtl/fp32_relu.sv
// Bit-level fp32 ReLU: negatives (incl. -0, negative denormals) become +0,
// positive NaNs collapse to the canonical quiet NaN, everything else passes.
module fp32_relu
  import bb_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] res,
  output logic        is_nan
);

  assign is_nan = !w[31] && (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  assign res    = w[31] ? FP32_ZERO : (is_nan ? FP32_QNAN : w);

endmodule

// File: rtl/vect_relu_argmax.sv
// Streams y out of its BRAM, applies ReLU and writes the result BRAM.
// Define VECT_RELU_ARGMAX_EN to build the argmax tracker reported in pl_status[31:16].
module vect_relu_argmax
  import bb_pkg::*;
#(
  parameter int addr_y_size = 12,
  parameter int addr_o_size = 12,
  parameter int length_M    = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ps_control,
  output logic [31:0]            pl_status,
  output logic [addr_y_size-1:0] bram_addr_y,
  input  logic [31:0]            bram_rddata_y,
  output logic [31:0]            bram_wrdata_y,
  output logic [3:0]             bram_we_y,
  output logic [addr_o_size-1:0] bram_addr_o,
  input  logic [31:0]            bram_rddata_o,
  output logic [31:0]            bram_wrdata_o,
  output logic [3:0]             bram_we_o
);

  localparam int IDX_W = 12;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(length_M - 1);

  state_t           state;
  logic [IDX_W-1:0] cnt_p0, cnt_nxt, idx_p1, idx_stat;
  logic             vld_p0, vld_p1;
  logic             drain_cnt;
  logic             done_r, busy_r;
  logic [31:0]      relu_w;
  logic             nan_w;
  logic             unused_bits;

  assign bram_wrdata_y = 32'h0;
  assign bram_we_y     = 4'h0;
  assign cnt_nxt       = cnt_p0 + IDX_W'(1);
  assign unused_bits   = ^{bram_rddata_o, ps_control[31:1], nan_w};

  fp32_relu u_relu (
    .w      (bram_rddata_y),
    .res    (relu_w),
    .is_nan (nan_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt_p0        <= '0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      idx_p1        <= '0;
      drain_cnt     <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      bram_addr_y   <= '0;
      bram_addr_o   <= '0;
      bram_wrdata_o <= '0;
      bram_we_o     <= 4'h0;
    end else begin
      // p0 -> p1: address is in the BRAM, data arrives during this stage
      vld_p1 <= vld_p0;
      idx_p1 <= cnt_p0;
      // p1 -> write: activated word goes straight to the output port
      bram_we_o <= vld_p1 ? 4'hF : 4'h0;
      if (vld_p1) begin
        bram_addr_o   <= addr_o_size'({idx_p1, 2'b00});
        bram_wrdata_o <= relu_w;
      end
      case (state)
        IDLE: if (ps_control[0]) begin
          state       <= RUN;
          cnt_p0      <= '0;
          vld_p0      <= 1'b1;
          busy_r      <= 1'b1;
          bram_addr_y <= '0;
        end
        RUN: if (cnt_p0 == LAST_IDX) begin
          state     <= DRAIN;
          vld_p0    <= 1'b0;
          drain_cnt <= 1'b0;
        end else begin
          cnt_p0      <= cnt_nxt;
          bram_addr_y <= addr_y_size'({cnt_nxt, 2'b00});
        end
        DRAIN: if (drain_cnt) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          drain_cnt <= 1'b1;
        end
        DONE: if (!ps_control[0]) begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VECT_RELU_ARGMAX_EN
  logic [IDX_W-1:0] best_idx;
  logic [30:0]      best_val;

  // Non-negative IEEE words order like unsigned ints; strict > keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && ps_control[0])) begin
      best_idx <= '0;
      best_val <= '0;
    end else if (vld_p1 && !nan_w && (relu_w[30:0] > best_val)) begin
      best_idx <= idx_p1;
      best_val <= relu_w[30:0];
    end
  end

  assign idx_stat = best_idx;
`else
  assign idx_stat = '0;
`endif

  always_comb begin
    pl_status                       = 32'h0;
    pl_status[STAT_DONE]            = done_r;
    pl_status[STAT_BUSY]            = busy_r;
    pl_status[STAT_IDX_LSB +: 16]   = 16'(idx_stat);
  end

endmodule

// File: tb/tb_vect_relu_argmax.sv
// Self-checking bench for vect_relu_argmax with a behavioural BRAM and ReLU/argmax model.
module tb_vect_relu_argmax;

  localparam int M = 128;
`ifdef VECT_RELU_ARGMAX_EN
  localparam bit ARGMAX_ON = 1'b1;
`else
  localparam bit ARGMAX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [11:0] bram_addr_y, bram_addr_o;
  logic [31:0] bram_rddata_y, bram_wrdata_y, bram_rddata_o, bram_wrdata_o;
  logic [3:0]  bram_we_y, bram_we_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] ymem  [M];
  logic [31:0] omem  [M];
  logic [31:0] exp_o [M];
  int          exp_idx;

  int nwr, done_edge, done_cycles, idx_at_done, idx_at_start;
  bit addr_ok, we_ok, busy_start, busy_done, timeout;

  vect_relu_argmax #(.addr_y_size(12), .addr_o_size(12), .length_M(M)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps_control    (ps_control),
    .pl_status     (pl_status),
    .bram_addr_y   (bram_addr_y),
    .bram_rddata_y (bram_rddata_y),
    .bram_wrdata_y (bram_wrdata_y),
    .bram_we_y     (bram_we_y),
    .bram_addr_o   (bram_addr_o),
    .bram_rddata_o (bram_rddata_o),
    .bram_wrdata_o (bram_wrdata_o),
    .bram_we_o     (bram_we_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read y BRAM
  always @(posedge clk) bram_rddata_y <= ymem[bram_addr_y[8:2]];

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0:       return $urandom;
      1:       return {1'b1, 31'($urandom)};
      2:       return {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
      3:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
      4:       return 32'h7F80_0000;
      5:       return ($urandom_range(0, 1) != 0) ? 32'h0000_0000 : 32'h8000_0000;
      default: return {1'b0, 8'd0, 23'($urandom)};
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < M; i++) ymem[i] = rand_word();
    for (int k = 0; k < 4; k++) ymem[$urandom_range(64, M-1)] = ymem[$urandom_range(0, 63)];
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < M; i++) ymem[i] = v;
  endtask

  // Reference: ReLU as a value rule, argmax as "largest non-NaN value, first occurrence".
  task automatic build_model();
    logic [31:0] w;
    logic [30:0] best;
    bit          nan;
    best = '0;
    exp_idx = 0;
    for (int i = 0; i < M; i++) begin
      w   = ymem[i];
      nan = (w[30:23] == 8'hFF) && (w[22:0] != 0);
      if (w[31])    exp_o[i] = 32'h0;
      else if (nan) exp_o[i] = 32'h7FC0_0000;
      else          exp_o[i] = w;
      if (!w[31] && !nan && w[30:0] > best) begin
        best    = w[30:0];
        exp_idx = i;
      end
    end
    if (!ARGMAX_ON) exp_idx = 0;
  endtask

  // Drives one run from IDLE and records what the DUT produced.
  task automatic do_run(input int drop_at, input bit hold);
    for (int i = 0; i < M; i++) omem[i] = 32'hDEAD_BEEF;
    nwr = 0; addr_ok = 1; we_ok = 1; done_edge = -1; done_cycles = 0; timeout = 0;
    idx_at_done = -1;
    ps_control = 32'h1;
    for (int c = 0; c < M + 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        busy_start   = pl_status[1];
        idx_at_start = int'(pl_status[31:16]);
      end
      if (c == drop_at) ps_control = 32'h0;
      if (bram_we_o == 4'hF) begin
        nwr++;
        if (c < 2 || c - 2 >= M || bram_addr_o != 12'(4 * (c - 2))) addr_ok = 0;
        else omem[c-2] = bram_wrdata_o;
      end else if (bram_we_o != 4'h0) we_ok = 0;
      if (pl_status[0]) begin
        if (done_edge < 0) begin
          done_edge   = c;
          idx_at_done = int'(pl_status[31:16]);
          busy_done   = pl_status[1];
        end
        done_cycles++;
        if (hold && done_cycles == 3) ps_control = 32'h0;
      end else if (done_edge >= 0) break;
    end
    if (done_edge < 0 || pl_status[0]) timeout = 1;
    ps_control = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1; ps_control = 0; bram_rddata_o = 32'hA5A5_A5A5;
    fill_const(32'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pl_status !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", pl_status); end
    checks++; if (bram_we_o !== 4'h0) begin errors++; $display("FAIL reset_we_o got %h want 0", bram_we_o); end
    checks++; if (bram_addr_y !== 12'h0 || bram_addr_o !== 12'h0) begin errors++; $display("FAIL reset_addr got y=%h o=%h want 0", bram_addr_y, bram_addr_o); end
    checks++; if (bram_wrdata_o !== 32'h0) begin errors++; $display("FAIL reset_wrdata_o got %h want 0", bram_wrdata_o); end
    checks++; if (bram_we_y !== 4'h0 || bram_wrdata_y !== 32'h0) begin errors++; $display("FAIL y_port_tied got we=%h wd=%h want 0", bram_we_y, bram_wrdata_y); end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    fill_const(32'h3F80_0000);
    build_model();
    do_run(-1, 1);
    checks++; if (timeout) begin errors++; $display("FAIL ones_timeout got no clean done want done"); end
    checks++; if (nwr != M) begin errors++; $display("FAIL ones_nwr got %0d want %0d", nwr, M); end
    checks++; if (!addr_ok || !we_ok) begin errors++; $display("FAIL ones_write_timing got addr_ok=%0d we_ok=%0d want 1", addr_ok, we_ok); end
    checks++; if (done_edge != M + 2) begin errors++; $display("FAIL ones_done_edge got %0d want %0d", done_edge, M + 2); end
    checks++; if (busy_start !== 1'b1 || busy_done !== 1'b0) begin errors++; $display("FAIL ones_busy got start=%0d done=%0d want 1/0", busy_start, busy_done); end
    checks++; if (done_cycles != 3) begin errors++; $display("FAIL ones_done_hold got %0d want 3", done_cycles); end
    checks++; if (idx_at_done != 0) begin errors++; $display("FAIL ones_argmax got %0d want 0", idx_at_done); end
    for (int i = 0; i < M; i++) begin
      checks++; if (omem[i] !== 32'h3F80_0000) begin errors++; $display("FAIL ones_out[%0d] got %h want 3f800000", i, omem[i]); end
    end
  endtask

  task automatic test_mixed();
    fill_const(32'h0);
    ymem[5] = 32'hC120_0000; ymem[9] = 32'h4120_0000; ymem[70] = 32'h42C8_0000;
    build_model();
    do_run(-1, 1);
    checks++; if (timeout || nwr != M) begin errors++; $display("FAIL mixed_run got nwr=%0d timeout=%0d want %0d/0", nwr, timeout, M); end
    checks++; if (omem[5] !== 32'h0) begin errors++; $display("FAIL mixed_out5 got %h want 0", omem[5]); end
    checks++; if (omem[9] !== 32'h4120_0000) begin errors++; $display("FAIL mixed_out9 got %h want 41200000", omem[9]); end
    checks++; if (omem[70] !== 32'h42C8_0000) begin errors++; $display("FAIL mixed_out70 got %h want 42c80000", omem[70]); end
    checks++; if (idx_at_done != (ARGMAX_ON ? 70 : 0)) begin errors++; $display("FAIL mixed_argmax got %0d want %0d", idx_at_done, ARGMAX_ON ? 70 : 0); end
    for (int i = 0; i < M; i++) begin
      checks++; if (omem[i] !== exp_o[i]) begin errors++; $display("FAIL mixed_out[%0d] got %h want %h", i, omem[i], exp_o[i]); end
    end
  endtask

  task automatic test_nan_tie();
    fill_const(32'h0);
    ymem[3] = 32'h4248_0000; ymem[40] = 32'h4248_0000;
    ymem[1] = 32'h7FC1_2345; ymem[0] = 32'h8000_0000;
    build_model();
    do_run(-1, 1);
    checks++; if (timeout) begin errors++; $display("FAIL nan_timeout got no clean done want done"); end
    checks++; if (omem[1] !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_out1 got %h want 7fc00000", omem[1]); end
    checks++; if (omem[0] !== 32'h0) begin errors++; $display("FAIL negzero_out0 got %h want 0", omem[0]); end
    checks++; if (omem[40] !== 32'h4248_0000) begin errors++; $display("FAIL tie_out40 got %h want 42480000", omem[40]); end
    checks++; if (idx_at_done != (ARGMAX_ON ? 3 : 0)) begin errors++; $display("FAIL tie_argmax got %0d want %0d", idx_at_done, ARGMAX_ON ? 3 : 0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random();
      build_model();
      do_run(-1, 1);
      checks++; if (timeout || nwr != M || !addr_ok || !we_ok) begin errors++; $display("FAIL rand%0d_writes got nwr=%0d addr_ok=%0d we_ok=%0d timeout=%0d", r, nwr, addr_ok, we_ok, timeout); end
      checks++; if (idx_at_done != exp_idx) begin errors++; $display("FAIL rand%0d_argmax got %0d want %0d", r, idx_at_done, exp_idx); end
      for (int i = 0; i < M; i++) begin
        checks++; if (omem[i] !== exp_o[i]) begin errors++; $display("FAIL rand%0d_out[%0d] got %h want %h", r, i, omem[i], exp_o[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_const(32'h3F00_0000);
    ymem[100] = 32'h4000_0000;
    build_model();
    do_run(-1, 1);
    checks++; if (idx_at_done != exp_idx) begin errors++; $display("FAIL b2b_first_argmax got %0d want %0d", idx_at_done, exp_idx); end
    fill_random();
    build_model();
    do_run(-1, 1);
    checks++; if (idx_at_start != 0) begin errors++; $display("FAIL b2b_argmax_clear got %0d want 0", idx_at_start); end
    checks++; if (done_edge != M + 2 || nwr != M) begin errors++; $display("FAIL b2b_second got done_edge=%0d nwr=%0d want %0d/%0d", done_edge, nwr, M + 2, M); end
    checks++; if (idx_at_done != exp_idx) begin errors++; $display("FAIL b2b_second_argmax got %0d want %0d", idx_at_done, exp_idx); end
    for (int i = 0; i < M; i++) begin
      checks++; if (omem[i] !== exp_o[i]) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", i, omem[i], exp_o[i]); end
    end
  endtask

  task automatic test_drop_start();
    fill_random();
    build_model();
    do_run(20, 0);
    checks++; if (timeout) begin errors++; $display("FAIL drop_timeout got no clean done want done"); end
    checks++; if (nwr != M || !addr_ok) begin errors++; $display("FAIL drop_writes got nwr=%0d addr_ok=%0d want %0d/1", nwr, addr_ok, M); end
    checks++; if (done_edge != M + 2) begin errors++; $display("FAIL drop_done_edge got %0d want %0d", done_edge, M + 2); end
    checks++; if (done_cycles != 1) begin errors++; $display("FAIL drop_done_width got %0d want 1", done_cycles); end
    checks++; if (idx_at_done != exp_idx) begin errors++; $display("FAIL drop_argmax got %0d want %0d", idx_at_done, exp_idx); end
    for (int i = 0; i < M; i++) begin
      checks++; if (omem[i] !== exp_o[i]) begin errors++; $display("FAIL drop_out[%0d] got %h want %h", i, omem[i], exp_o[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] we_before;
    fill_random();
    ps_control = 32'h1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
    end
    we_before = bram_we_o;
    reset = 1;
    @(posedge clk); #1;
    checks++; if (we_before !== 4'hF) begin errors++; $display("FAIL midrst_writing_before got %h want f", we_before); end
    checks++; if (bram_we_o !== 4'h0) begin errors++; $display("FAIL midrst_we_o got %h want 0", bram_we_o); end
    checks++; if (pl_status !== 32'h0) begin errors++; $display("FAIL midrst_status got %h want 0", pl_status); end
    checks++; if (bram_addr_y !== 12'h0 || bram_addr_o !== 12'h0 || bram_wrdata_o !== 32'h0) begin errors++; $display("FAIL midrst_outputs got ay=%h ao=%h wd=%h want 0", bram_addr_y, bram_addr_o, bram_wrdata_o); end
    reset = 0; ps_control = 32'h0;
    @(posedge clk); #1;
    fill_random();
    build_model();
    do_run(-1, 1);
    checks++; if (timeout || nwr != M || done_edge != M + 2) begin errors++; $display("FAIL midrst_rerun got nwr=%0d done_edge=%0d timeout=%0d", nwr, done_edge, timeout); end
    checks++; if (idx_at_done != exp_idx) begin errors++; $display("FAIL midrst_argmax got %0d want %0d", idx_at_done, exp_idx); end
    for (int i = 0; i < M; i++) begin
      checks++; if (omem[i] !== exp_o[i]) begin errors++; $display("FAIL midrst_out[%0d] got %h want %h", i, omem[i], exp_o[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_mixed();
    test_nan_tie();
    test_random();
    test_back_to_back();
    test_drop_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
